// File: rtl/imu_pkg.sv
// Shared types and SPI command words for the IMU command sequencer.
// The command words are fixed register writes and reads for the yaw gyro.
package imu_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    CFG1,
    CFG2,
    CFG3,
    IDLE,
    RDL,
    RDH
  } imu_state_t;

  localparam logic [15:0] CMD_INT_CFG  = 16'h0D02;
  localparam logic [15:0] CMD_GYRO_CFG = 16'h1160;
  localparam logic [15:0] CMD_CTRL_CFG = 16'h1440;
  localparam logic [15:0] CMD_RD_YAWL  = 16'hA600;
  localparam logic [15:0] CMD_RD_YAWH  = 16'hA700;

endpackage

// File: rtl/int_sync.sv
// Brings the asynchronous sensor interrupt into the clk domain.
// Produces a one-cycle strobe on each rising edge of the input.
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/imu_cmd_seq.sv
// Drives the SPI monarch: three config writes after power-up, then a
// low/high yaw-rate read pair for every sensor data-ready interrupt.
module imu_cmd_seq
  import imu_pkg::*;
#(
  parameter int PWRUP_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        cfg_rdy
);

  localparam logic [15:0] PWRUP_LAST = 16'(PWRUP_CYC - 1);

  imu_state_t  state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  lo_byte, lo_byte_n;
  logic        pend, pend_n;
  logic        wrt_n, vld_n, cfg_rdy_n;
  logic [15:0] cmd_n, yaw_rt_n;
  logic        int_rise;
  logic        int_ok;
  logic        done_q;

  int_sync u_int_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (INT),
    .rise     (int_rise)
  );

  // done is still high from the previous transaction while wrt is out
  assign done_q = done & ~wrt;
  assign int_ok = int_rise & cfg_rdy;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lo_byte_n = lo_byte;
    pend_n    = pend;
    wrt_n     = 1'b0;
    cmd_n     = cmd;
    yaw_rt_n  = yaw_rt;
    vld_n     = 1'b0;
    cfg_rdy_n = cfg_rdy;
    case (state)
      PWRUP: begin
        if (cnt == PWRUP_LAST) begin
          wrt_n   = 1'b1;
          cmd_n   = CMD_INT_CFG;
          state_n = CFG1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      CFG1: if (done_q) begin
        wrt_n   = 1'b1;
        cmd_n   = CMD_GYRO_CFG;
        state_n = CFG2;
      end
      CFG2: if (done_q) begin
        wrt_n   = 1'b1;
        cmd_n   = CMD_CTRL_CFG;
        state_n = CFG3;
      end
      CFG3: if (done_q) begin
        cfg_rdy_n = 1'b1;
        state_n   = IDLE;
      end
      IDLE: if (int_ok || pend) begin
        pend_n  = 1'b0;
        wrt_n   = 1'b1;
        cmd_n   = CMD_RD_YAWL;
        state_n = RDL;
      end
      RDL: begin
        // a single pending slot; further rises while it is set are dropped
        if (int_ok) pend_n = 1'b1;
        if (done_q) begin
          lo_byte_n = rd_data[7:0];
          wrt_n     = 1'b1;
          cmd_n     = CMD_RD_YAWH;
          state_n   = RDH;
        end
      end
      RDH: begin
        if (int_ok) pend_n = 1'b1;
        if (done_q) begin
          yaw_rt_n = {rd_data[7:0], lo_byte};
          vld_n    = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= PWRUP;
      cnt     <= 16'h0000;
      lo_byte <= 8'h00;
      pend    <= 1'b0;
      wrt     <= 1'b0;
      cmd     <= 16'h0000;
      yaw_rt  <= 16'h0000;
      vld     <= 1'b0;
      cfg_rdy <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lo_byte <= lo_byte_n;
      pend    <= pend_n;
      wrt     <= wrt_n;
      cmd     <= cmd_n;
      yaw_rt  <= yaw_rt_n;
      vld     <= vld_n;
      cfg_rdy <= cfg_rdy_n;
    end
  end

endmodule
